// File: rtl/motor_seq_pkg.sv
// Shared state codes, H-bridge codes and helpers for the turntable motor sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package motor_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_BRAKE     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BR_COAST = 2'b00,
        BR_FWD   = 2'b01,
        BR_REV   = 2'b10,
        BR_BRK   = 2'b11
    } bridge_t;

    localparam int PWM_PERIOD = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bridge code that drives the motor in the given direction (0 forward, 1 reverse).
    function automatic bridge_t drive_code(input logic d);
        return d ? BR_REV : BR_FWD;
    endfunction

endpackage

// File: rtl/turntable_motor_sequencer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is a decode of the registered count (asserted while count = TICK_DIV-1).
// Backpressure: none; never stalls and is not restarted by the consumer.
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap at TICK_DIV-1, otherwise count up.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/turntable_motor_sequencer.sv
// Turntable DC motor sequencer: soft-start ramp, run, periodic reversal, soft stop, timed brake.
// Latency: every transition and output change lands on the clock edge after its condition.
// Backpressure: none; level inputs are sampled every cycle, door_open overrides all motion.
module turntable_motor_sequencer
    import motor_seq_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int STEP_MS    = 50,
    parameter int DUTY_MAX   = 7,
    parameter int REV_MS     = 5000,
    parameter int BRAKE_MS   = 200,
    parameter bit REVERSE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_req,
    input  logic       door_open,
    output logic [3:0] duty,
    output logic [1:0] in1_in2,
    output logic       dir,
    output logic       running,
    output logic [2:0] state_o
);

    // Run duty clamped into 1..PWM_PERIOD so the 4-bit duty can never exceed 10.
    localparam int DMAX = (DUTY_MAX > PWM_PERIOD) ? PWM_PERIOD : ((DUTY_MAX < 1) ? 1 : DUTY_MAX);
    localparam logic [3:0] DMAX4 = 4'(DMAX);

    // One shared timer serves step, reversal and brake intervals; states never overlap.
    localparam int TMAX = max3(STEP_MS, REV_MS, BRAKE_MS);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_MS - 1);
    localparam logic [TW-1:0] REV_LAST   = TW'(REV_MS - 1);
    localparam logic [TW-1:0] BRAKE_LAST = TW'(BRAKE_MS - 1);

    logic tick;

    state_t        state_q, state_d;
    logic [3:0]    duty_q, duty_d;
    bridge_t       br_q, br_d;
    logic          dir_q, dir_d;
    logic          rp_q, rp_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic       step_exp, rev_exp, brake_exp;
    logic [3:0] duty_up, duty_dn;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign step_exp  = tick && (tmr_q == STEP_LAST);
    assign rev_exp   = tick && (tmr_q == REV_LAST);
    assign brake_exp = tick && (tmr_q == BRAKE_LAST);

    // Saturating duty steps keep the ramp inside 0..DMAX.
    assign duty_up = (duty_q >= DMAX4) ? DMAX4 : duty_q + 4'd1;
    assign duty_dn = (duty_q == 4'd0) ? 4'd0 : duty_q - 4'd1;

    // Next-state, timer and output-register decode.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        br_d    = br_q;
        dir_d   = dir_q;
        rp_d    = rp_q;
        tmr_d   = tick ? tmr_q + TW'(1) : tmr_q;

        case (state_q)
            S_IDLE: begin
                duty_d = 4'd0;
                br_d   = BR_COAST;
                if (run_req && !door_open) begin
                    state_d = S_RAMP_UP;
                    duty_d  = 4'd1;
                    br_d    = drive_code(dir_q);
                    tmr_d   = '0;
                end
            end
            S_RAMP_UP: begin
                if (door_open) begin
                    state_d = S_BRAKE;
                    duty_d  = 4'd0;
                    br_d    = BR_BRK;
                    rp_d    = 1'b0;
                    tmr_d   = '0;
                end else if (!run_req) begin
                    state_d = S_RAMP_DOWN;
                    rp_d    = 1'b0;
                    tmr_d   = '0;
                end else if (step_exp) begin
                    duty_d = duty_up;
                    tmr_d  = '0;
                    if (duty_up == DMAX4) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                duty_d = DMAX4;
                if (door_open) begin
                    state_d = S_BRAKE;
                    duty_d  = 4'd0;
                    br_d    = BR_BRK;
                    rp_d    = 1'b0;
                    tmr_d   = '0;
                end else if (!run_req) begin
                    state_d = S_RAMP_DOWN;
                    rp_d    = 1'b0;
                    tmr_d   = '0;
                end else if (REVERSE_EN && rev_exp) begin
                    state_d = S_RAMP_DOWN;
                    rp_d    = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_RAMP_DOWN: begin
                if (door_open) begin
                    state_d = S_BRAKE;
                    duty_d  = 4'd0;
                    br_d    = BR_BRK;
                    rp_d    = 1'b0;
                    tmr_d   = '0;
                end else if (!rp_q && run_req) begin
                    // A stop ramp can be resumed; a reversal ramp must reach BRAKE.
                    state_d = S_RAMP_UP;
                    tmr_d   = '0;
                end else if (step_exp) begin
                    duty_d = duty_dn;
                    tmr_d  = '0;
                    if (duty_dn == 4'd0) begin
                        state_d = S_BRAKE;
                        br_d    = BR_BRK;
                    end
                end
            end
            S_BRAKE: begin
                duty_d = 4'd0;
                br_d   = BR_BRK;
                if (door_open) begin
                    rp_d = 1'b0;
                end
                if (brake_exp) begin
                    rp_d  = 1'b0;
                    tmr_d = '0;
                    if (rp_q && run_req && !door_open) begin
                        state_d = S_RAMP_UP;
                        dir_d   = ~dir_q;
                        duty_d  = 4'd1;
                        br_d    = drive_code(~dir_q);
                    end else begin
                        state_d = S_IDLE;
                        br_d    = BR_COAST;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                duty_d  = 4'd0;
                br_d    = BR_COAST;
                rp_d    = 1'b0;
                tmr_d   = '0;
            end
        endcase
    end

    // State, timer and registered motor outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            duty_q  <= 4'd0;
            br_q    <= BR_COAST;
            dir_q   <= 1'b0;
            rp_q    <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            br_q    <= br_d;
            dir_q   <= dir_d;
            rp_q    <= rp_d;
            tmr_q   <= tmr_d;
        end
    end

    assign duty    = duty_q;
    assign in1_in2 = br_q;
    assign dir     = dir_q;
    assign running = (state_q != S_IDLE);
    assign state_o = state_q;

endmodule
